// File: rtl/edit_mem_shared_memory_mc_pkg.sv
// rtl/edit_mem_shared_memory_mc_pkg.sv - shared widths, arbiter state type and round-robin helper
package edit_mem_shared_memory_mc_pkg;

    localparam int EM_BUF_PTR_NBITS     = 10;
    localparam int EM_BUF_PTR_LSB_NBITS = 2;
    localparam int DATA_PATH_NBITS      = 512;
    localparam int PORT_ID_NBITS        = 4;
    localparam int EM_RD_CH             = 4;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Next round-robin start position after serving channel cur out of num.
    function automatic int rr_next(input int cur, input int num);
        return (cur + 1 >= num) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/edit_mem_shared_memory_mc_if.sv
// rtl/edit_mem_shared_memory_mc_if.sv - write port, read request and read response bundle
// master: processing units / egress requesters (drive writes and requests)
// slave : shared edit memory (drives grants, releases and read responses)
interface edit_mem_shared_memory_mc_if
    import edit_mem_shared_memory_mc_pkg::*;
#(
    parameter int BPTR_NBITS     = EM_BUF_PTR_NBITS,
    parameter int BPTR_LSB_NBITS = EM_BUF_PTR_LSB_NBITS,
    parameter int DATA_NBITS     = DATA_PATH_NBITS,
    parameter int ID_NBITS       = PORT_ID_NBITS,
    parameter int NUM_CH         = EM_RD_CH,
    parameter int CH_NBITS       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic                               pu_data_valid;
    logic [BPTR_NBITS-1:0]              pu_data_buf_ptr;
    logic [BPTR_LSB_NBITS-1:0]          pu_data_buf_ptr_lsb;
    logic [DATA_NBITS-1:0]              pu_data;

    logic [NUM_CH-1:0]                  data_req;
    logic [NUM_CH-1:0]                  data_req_ready;
    logic [NUM_CH*ID_NBITS-1:0]         data_req_dst_port_id;
    logic [NUM_CH-1:0]                  data_req_sop;
    logic [NUM_CH-1:0]                  data_req_eop;
    logic [NUM_CH*BPTR_NBITS-1:0]       data_req_buf_ptr;
    logic [NUM_CH*BPTR_LSB_NBITS-1:0]   data_req_buf_ptr_lsb;

    logic                               em_rel_buf_valid;
    logic [BPTR_NBITS-1:0]              em_rel_buf_ptr;
    logic [CH_NBITS-1:0]                em_rel_buf_ch;

    logic                               edit_mem_ack;
    logic [CH_NBITS-1:0]                edit_mem_ack_ch;
    logic [ID_NBITS-1:0]                edit_mem_ack_dst_port_id;
    logic                               edit_mem_ack_sop;
    logic                               edit_mem_ack_eop;
    logic [DATA_NBITS-1:0]              edit_mem_rdata;

    modport master (
        output pu_data_valid, pu_data_buf_ptr, pu_data_buf_ptr_lsb, pu_data,
        output data_req, data_req_dst_port_id, data_req_sop, data_req_eop,
        output data_req_buf_ptr, data_req_buf_ptr_lsb,
        input  data_req_ready,
        input  em_rel_buf_valid, em_rel_buf_ptr, em_rel_buf_ch,
        input  edit_mem_ack, edit_mem_ack_ch, edit_mem_ack_dst_port_id,
        input  edit_mem_ack_sop, edit_mem_ack_eop, edit_mem_rdata
    );

    modport slave (
        input  pu_data_valid, pu_data_buf_ptr, pu_data_buf_ptr_lsb, pu_data,
        input  data_req, data_req_dst_port_id, data_req_sop, data_req_eop,
        input  data_req_buf_ptr, data_req_buf_ptr_lsb,
        output data_req_ready,
        output em_rel_buf_valid, em_rel_buf_ptr, em_rel_buf_ch,
        output edit_mem_ack, edit_mem_ack_ch, edit_mem_ack_dst_port_id,
        output edit_mem_ack_sop, edit_mem_ack_eop, edit_mem_rdata
    );
endinterface

// File: rtl/edit_mem_shared_memory_mc_rr_arb.sv
// rtl/edit_mem_shared_memory_mc_rr_arb.sv - round-robin read-port arbiter with optional packet lock
// Ports: clk, rstn (async active-low); req_i/sop_i/eop_i per channel;
//        gnt_o one-hot grant (combinational), gnt_ch_o granted index, gnt_valid_o any grant.
module edit_mem_shared_memory_mc_rr_arb
    import edit_mem_shared_memory_mc_pkg::*;
#(
    parameter int NUM_CH   = EM_RD_CH,
    parameter int CH_NBITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int PKT_LOCK = 0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NUM_CH-1:0]   req_i,
    input  logic [NUM_CH-1:0]   sop_i,
    input  logic [NUM_CH-1:0]   eop_i,
    output logic [NUM_CH-1:0]   gnt_o,
    output logic [CH_NBITS-1:0] gnt_ch_o,
    output logic                gnt_valid_o
);

    arb_state_e          state_q;
    logic [CH_NBITS-1:0] ptr_q;
    logic [CH_NBITS-1:0] lock_ch_q;
    int                  cand;

    always_comb begin
        gnt_o       = '0;
        gnt_ch_o    = '0;
        gnt_valid_o = 1'b0;
        cand        = 0;
        if (PKT_LOCK != 0 && state_q == ARB_LOCKED) begin
            // Locked channel owns the port even while it is not requesting.
            gnt_ch_o    = lock_ch_q;
            gnt_valid_o = req_i[lock_ch_q];
        end else begin
            // Walk from farthest to nearest so the channel closest to the
            // pointer is the last (winning) assignment.
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                cand = int'(ptr_q) + i;
                if (cand >= NUM_CH) cand = cand - NUM_CH;
                if (req_i[cand]) begin
                    gnt_ch_o    = CH_NBITS'(cand);
                    gnt_valid_o = 1'b1;
                end
            end
        end
        gnt_o[gnt_ch_o] = gnt_valid_o;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ARB_IDLE;
            ptr_q     <= '0;
            lock_ch_q <= '0;
        end else if (gnt_valid_o) begin
            ptr_q <= CH_NBITS'(rr_next(int'(gnt_ch_o), NUM_CH));
            case (state_q)
                ARB_IDLE: begin
                    if (PKT_LOCK != 0 && sop_i[gnt_ch_o] && !eop_i[gnt_ch_o]) begin
                        state_q   <= ARB_LOCKED;
                        lock_ch_q <= gnt_ch_o;
                    end
                end
                ARB_LOCKED: begin
                    if (eop_i[gnt_ch_o]) state_q <= ARB_IDLE;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/edit_mem_shared_memory_mc.sv
// rtl/edit_mem_shared_memory_mc.sv - multi-channel shared packet buffer with arbitrated tagged reads
// Ports: clk, rstn (async active-low), bus (slave modport):
//        pu_* single write port; data_req* per-channel read requests with data_req_ready grant;
//        em_rel_buf_* buffer release; edit_mem_ack*/edit_mem_rdata tagged read response.
module edit_mem_shared_memory_mc
    import edit_mem_shared_memory_mc_pkg::*;
#(
    parameter int BPTR_NBITS     = EM_BUF_PTR_NBITS,
    parameter int BPTR_LSB_NBITS = EM_BUF_PTR_LSB_NBITS,
    parameter int DATA_NBITS     = DATA_PATH_NBITS,
    parameter int ID_NBITS       = PORT_ID_NBITS,
    parameter int NUM_CH         = EM_RD_CH,
    parameter int CH_NBITS       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int RAM_LAT        = 1,
    parameter int PKT_LOCK       = 0
) (
    input  logic clk,
    input  logic rstn,
    edit_mem_shared_memory_mc_if.slave bus
);

    localparam int ADDR_NBITS = BPTR_NBITS + BPTR_LSB_NBITS;
    localparam int DEPTH      = 1 << ADDR_NBITS;

    logic [DATA_NBITS-1:0]  mem [DEPTH];

    // Registered write port
    logic                   wr_valid_q;
    logic [ADDR_NBITS-1:0]  wr_addr_q;
    logic [DATA_NBITS-1:0]  wr_data_q;

    // Arbiter result
    logic [NUM_CH-1:0]      gnt;
    logic [CH_NBITS-1:0]    gnt_ch;
    logic                   gnt_valid;
    logic [ADDR_NBITS-1:0]  sel_addr;
    logic [ID_NBITS-1:0]    sel_dst;

    // S1: address presented to the RAM read port
    logic                   s1_valid_q;
    logic [ADDR_NBITS-1:0]  s1_addr_q;
    logic [CH_NBITS-1:0]    s1_ch_q;
    logic [ID_NBITS-1:0]    s1_dst_q;
    logic                   s1_sop_q;
    logic                   s1_eop_q;
    logic                   s1_hit;

    // RAM latency stages: tags travel alongside the RAM read data
    logic [RAM_LAT-1:0]     p_valid_q;
    logic [DATA_NBITS-1:0]  rd_q       [RAM_LAT];
    logic [CH_NBITS-1:0]    p_ch_q     [RAM_LAT];
    logic [ID_NBITS-1:0]    p_dst_q    [RAM_LAT];
    logic                   p_sop_q    [RAM_LAT];
    logic                   p_eop_q    [RAM_LAT];
    logic                   p_fwd_q    [RAM_LAT];
    logic [DATA_NBITS-1:0]  p_fwd_d_q  [RAM_LAT];

    // Outputs
    logic                   ack_q;
    logic [CH_NBITS-1:0]    ack_ch_q;
    logic [ID_NBITS-1:0]    ack_dst_q;
    logic                   ack_sop_q;
    logic                   ack_eop_q;
    logic [DATA_NBITS-1:0]  rdata_q;
    logic                   rel_valid_q;
    logic [BPTR_NBITS-1:0]  rel_ptr_q;
    logic [CH_NBITS-1:0]    rel_ch_q;

    edit_mem_shared_memory_mc_rr_arb #(
        .NUM_CH   (NUM_CH),
        .CH_NBITS (CH_NBITS),
        .PKT_LOCK (PKT_LOCK)
    ) u_arb (
        .clk         (clk),
        .rstn        (rstn),
        .req_i       (bus.data_req),
        .sop_i       (bus.data_req_sop),
        .eop_i       (bus.data_req_eop),
        .gnt_o       (gnt),
        .gnt_ch_o    (gnt_ch),
        .gnt_valid_o (gnt_valid)
    );

    assign sel_addr = {bus.data_req_buf_ptr[int'(gnt_ch)*BPTR_NBITS +: BPTR_NBITS],
                       bus.data_req_buf_ptr_lsb[int'(gnt_ch)*BPTR_LSB_NBITS +: BPTR_LSB_NBITS]};
    assign sel_dst  = bus.data_req_dst_port_id[int'(gnt_ch)*ID_NBITS +: ID_NBITS];

    // The RAM only sees this write at the end of the cycle, so a read of the
    // same address in this cycle must take the data from the write register.
    assign s1_hit = wr_valid_q && (wr_addr_q == s1_addr_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_valid_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            p_valid_q   <= '0;
            ack_q       <= 1'b0;
            rel_valid_q <= 1'b0;
        end else begin
            wr_valid_q   <= bus.pu_data_valid;
            s1_valid_q   <= gnt_valid;
            p_valid_q[0] <= s1_valid_q;
            for (int i = 1; i < RAM_LAT; i++) p_valid_q[i] <= p_valid_q[i-1];
            ack_q        <= p_valid_q[RAM_LAT-1];
            // Release on the last line of a buffer or at end of packet.
            rel_valid_q  <= s1_valid_q && ((&s1_addr_q[BPTR_LSB_NBITS-1:0]) || s1_eop_q);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_valid_q) mem[wr_addr_q] <= wr_data_q;
        wr_addr_q <= {bus.pu_data_buf_ptr, bus.pu_data_buf_ptr_lsb};
        wr_data_q <= bus.pu_data;

        if (gnt_valid) begin
            s1_addr_q <= sel_addr;
            s1_ch_q   <= gnt_ch;
            s1_dst_q  <= sel_dst;
            s1_sop_q  <= bus.data_req_sop[gnt_ch];
            s1_eop_q  <= bus.data_req_eop[gnt_ch];
        end

        rd_q[0]      <= mem[s1_addr_q];
        p_ch_q[0]    <= s1_ch_q;
        p_dst_q[0]   <= s1_dst_q;
        p_sop_q[0]   <= s1_sop_q;
        p_eop_q[0]   <= s1_eop_q;
        p_fwd_q[0]   <= s1_hit;
        p_fwd_d_q[0] <= wr_data_q;
        for (int i = 1; i < RAM_LAT; i++) begin
            rd_q[i]      <= rd_q[i-1];
            p_ch_q[i]    <= p_ch_q[i-1];
            p_dst_q[i]   <= p_dst_q[i-1];
            p_sop_q[i]   <= p_sop_q[i-1];
            p_eop_q[i]   <= p_eop_q[i-1];
            p_fwd_q[i]   <= p_fwd_q[i-1];
            p_fwd_d_q[i] <= p_fwd_d_q[i-1];
        end

        ack_ch_q  <= p_ch_q[RAM_LAT-1];
        ack_dst_q <= p_dst_q[RAM_LAT-1];
        ack_sop_q <= p_sop_q[RAM_LAT-1];
        ack_eop_q <= p_eop_q[RAM_LAT-1];
        rdata_q   <= p_fwd_q[RAM_LAT-1] ? p_fwd_d_q[RAM_LAT-1] : rd_q[RAM_LAT-1];

        rel_ptr_q <= s1_addr_q[ADDR_NBITS-1 -: BPTR_NBITS];
        rel_ch_q  <= s1_ch_q;
    end

    assign bus.data_req_ready           = gnt;
    assign bus.em_rel_buf_valid         = rel_valid_q;
    assign bus.em_rel_buf_ptr           = rel_ptr_q;
    assign bus.em_rel_buf_ch            = rel_ch_q;
    assign bus.edit_mem_ack             = ack_q;
    assign bus.edit_mem_ack_ch          = ack_ch_q;
    assign bus.edit_mem_ack_dst_port_id = ack_dst_q;
    assign bus.edit_mem_ack_sop         = ack_sop_q;
    assign bus.edit_mem_ack_eop         = ack_eop_q;
    assign bus.edit_mem_rdata           = rdata_q;

endmodule
